id_hazard_ctrl: RTL and testbench

- Control-side counterpart of the ID/EXE stage register. It tracks every instruction the ID/EXE register releases into EXE, MEM and WB, using a 3-entry in-flight scoreboard.
- From that scoreboard it decides each cycle whether the ID stage must freeze and whether the ID/EXE register must capture a bubble (NOP).
- It also flushes IF/ID and ID/EXE on a taken branch and keeps stall and flush event counters for performance debug.

---
 rtl/id_hazard_ctrl_if.sv | 34 +++
 rtl/id_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_if.sv
// Hazard-control bundle between the ID stage and id_hazard_ctrl.
// The slave modport is the controller's view. The master modport is the
// view of the pipeline or bench that drives the ID-stage fields and
// consumes the stall/flush decisions.
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Src1_ID;
    logic [4:0]       Src2_ID;
    logic             Src2_used_ID;
    logic             WB_EN_ID;
    logic [1:0]       MEM_CMD_ID;
    logic [4:0]       Dst_ID;
    logic             Br_taken;
    logic             Mem_wait;
    logic             Freeze;
    logic             Bubble;
    logic             Flush;
    logic             Hold_all;
    logic [CNT_W-1:0] Stall_cnt;
    logic [CNT_W-1:0] Flush_cnt;

    modport slave (
        input  Src1_ID, Src2_ID, Src2_used_ID, WB_EN_ID, MEM_CMD_ID, Dst_ID,
               Br_taken, Mem_wait,
        output Freeze, Bubble, Flush, Hold_all, Stall_cnt, Flush_cnt
    );

    modport master (
        output Src1_ID, Src2_ID, Src2_used_ID, WB_EN_ID, MEM_CMD_ID, Dst_ID,
               Br_taken, Mem_wait,
        input  Freeze, Bubble, Flush, Hold_all, Stall_cnt, Flush_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller.
// A 3-entry scoreboard shadows the instructions in EXE, MEM and WB.
// From it the controller decides each cycle whether ID freezes and whether
// ID/EXE captures a bubble. It raises Flush on a taken branch and passes
// Mem_wait through as a whole-pipeline hold. Stall and flush events are
// counted for performance debug.
module id_hazard_ctrl #(
    parameter int FWD_EN    = 1,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    id_hazard_ctrl_if.slave          hz
);
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       is_load;
        logic [4:0] dst;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wb_en: 1'b0, is_load: 1'b0, dst: 5'd0};

    sb_entry_t        sb_exe_r;
    sb_entry_t        sb_mem_r;
    sb_entry_t        sb_wb_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             exe_hit_s;
    logic             mem_hit_s;
    logic             wb_hit_s;
    logic             hazard_s;
    logic             freeze_s;
    logic             bubble_s;
    logic             flush_s;
    sb_entry_t        sb_exe_next_s;

    // A source hits an entry only if that entry will write it back.
    // Register 0 is hard-wired, so it can never hit.
    function automatic logic src_hit(input sb_entry_t e, input logic [4:0] src);
        return e.valid && e.wb_en && (e.dst == src) && (src != 5'd0);
    endfunction

    // An entry matches the ID instruction via Src1, or via Src2 when Src2 is read.
    function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic s2_used);
        return src_hit(e, s1) || (s2_used && src_hit(e, s2));
    endfunction

    assign exe_hit_s = entry_hit(sb_exe_r, hz.Src1_ID, hz.Src2_ID, hz.Src2_used_ID);
    assign mem_hit_s = entry_hit(sb_mem_r, hz.Src1_ID, hz.Src2_ID, hz.Src2_used_ID);
    assign wb_hit_s  = entry_hit(sb_wb_r,  hz.Src1_ID, hz.Src2_ID, hz.Src2_used_ID);

    // Raw hazard detection.
    // With forwarding, only a load still in EXE stalls.
    // Without forwarding, any in-flight writer stalls, except one in WB
    // when the register file writes in the first half-cycle.
    always_comb begin
        hazard_s = 1'b0;
        if (FWD_EN != 0) begin
            hazard_s = exe_hit_s && sb_exe_r.is_load;
        end else if (WB_BYPASS != 0) begin
            hazard_s = exe_hit_s || mem_hit_s;
        end else begin
            hazard_s = exe_hit_s || mem_hit_s || wb_hit_s;
        end
    end

    // Output priority: memory wait holds everything.
    // A taken branch then squashes ID, which makes any hazard irrelevant.
    always_comb begin
        freeze_s = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        if (hz.Mem_wait) begin
            freeze_s = 1'b0;
            bubble_s = 1'b0;
            flush_s  = 1'b0;
        end else if (hz.Br_taken) begin
            flush_s  = 1'b1;
        end else if (hazard_s) begin
            freeze_s = 1'b1;
            bubble_s = 1'b1;
        end else begin
            freeze_s = 1'b0;
            bubble_s = 1'b0;
            flush_s  = 1'b0;
        end
    end

    // The entry that ID/EXE will release into EXE: a NOP on bubble or
    // flush, otherwise the ID instruction's write-back view.
    always_comb begin
        sb_exe_next_s = SB_EMPTY;
        if (flush_s || bubble_s) begin
            sb_exe_next_s = SB_EMPTY;
        end else begin
            sb_exe_next_s.valid   = 1'b1;
            sb_exe_next_s.wb_en   = hz.WB_EN_ID;
            sb_exe_next_s.is_load = (hz.MEM_CMD_ID == 2'b01);
            sb_exe_next_s.dst     = hz.Dst_ID;
        end
    end

    // Scoreboard shift register. It follows the pipeline and freezes with it on Mem_wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_exe_r <= SB_EMPTY;
            sb_mem_r <= SB_EMPTY;
            sb_wb_r  <= SB_EMPTY;
        end else if (hz.Mem_wait) begin
            sb_exe_r <= sb_exe_r;
            sb_mem_r <= sb_mem_r;
            sb_wb_r  <= sb_wb_r;
        end else begin
            sb_wb_r  <= sb_mem_r;
            sb_mem_r <= sb_exe_r;
            sb_exe_r <= sb_exe_next_s;
        end
    end

    // Free-running, wrapping event counters for hazard bubbles and flushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (hz.Mem_wait) begin
            stall_cnt_r <= stall_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end else begin
            if (bubble_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hz.Freeze    = freeze_s;
    assign hz.Bubble    = bubble_s;
    assign hz.Flush     = flush_s;
    assign hz.Hold_all  = hz.Mem_wait;
    assign hz.Stall_cnt = stall_cnt_r;
    assign hz.Flush_cnt = flush_cnt_r;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl.
// Three instances share one stimulus stream:
//   u_f: forwarding present.
//   u_b: no forwarding, write-first register file.
//   u_n: no forwarding, no WB bypass, 2-bit counters so that wrap is reachable.
// Inputs change 1 ns after the rising edge.
// Combinational outputs are checked 3 ns after the edge.
module tb_id_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] src1, src2, dst;
    logic       u2, wb, br, mw;
    logic [1:0] mc;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.CNT_W(32)) ifc_f ();
    id_hazard_ctrl_if #(.CNT_W(32)) ifc_b ();
    id_hazard_ctrl_if #(.CNT_W(2))  ifc_n ();

    assign ifc_f.Src1_ID = src1; assign ifc_f.Src2_ID = src2; assign ifc_f.Src2_used_ID = u2;
    assign ifc_f.WB_EN_ID = wb;  assign ifc_f.MEM_CMD_ID = mc; assign ifc_f.Dst_ID = dst;
    assign ifc_f.Br_taken = br;  assign ifc_f.Mem_wait = mw;
    assign ifc_b.Src1_ID = src1; assign ifc_b.Src2_ID = src2; assign ifc_b.Src2_used_ID = u2;
    assign ifc_b.WB_EN_ID = wb;  assign ifc_b.MEM_CMD_ID = mc; assign ifc_b.Dst_ID = dst;
    assign ifc_b.Br_taken = br;  assign ifc_b.Mem_wait = mw;
    assign ifc_n.Src1_ID = src1; assign ifc_n.Src2_ID = src2; assign ifc_n.Src2_used_ID = u2;
    assign ifc_n.WB_EN_ID = wb;  assign ifc_n.MEM_CMD_ID = mc; assign ifc_n.Dst_ID = dst;
    assign ifc_n.Br_taken = br;  assign ifc_n.Mem_wait = mw;

    id_hazard_ctrl #(.FWD_EN(1), .WB_BYPASS(1), .CNT_W(32)) u_f (.clk(clk), .rst(rst), .hz(ifc_f));
    id_hazard_ctrl #(.FWD_EN(0), .WB_BYPASS(1), .CNT_W(32)) u_b (.clk(clk), .rst(rst), .hz(ifc_b));
    id_hazard_ctrl #(.FWD_EN(0), .WB_BYPASS(0), .CNT_W(2))  u_n (.clk(clk), .rst(rst), .hz(ifc_n));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic put(input logic [4:0] s1, input logic [4:0] s2, input logic s2u,
                       input logic w, input logic [1:0] m, input logic [4:0] d);
        src1 = s1; src2 = s2; u2 = s2u; wb = w; mc = m; dst = d;
    endtask

    task automatic nop();
        put(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0);
    endtask

    task automatic do_reset();
        nop();
        br  = 1'b0;
        mw  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; br = 1'b0; mw = 1'b0;
        nop();
        tick();
        tick();
        rst = 1'b1;
        settle();
        check("rst_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        check("rst_bubble", {31'd0, ifc_f.Bubble}, 32'd0);
        check("rst_flush",  {31'd0, ifc_f.Flush},  32'd0);
        check("rst_stall_cnt", ifc_f.Stall_cnt, 32'd0);
        check("rst_flush_cnt", ifc_f.Flush_cnt, 32'd0);

        // 1: load r5, then dependent add -> one stall with forwarding
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 5'd5);
        settle();
        check("t1_load_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        tick();
        put(5'd5, 5'd0, 1'b0, 1'b1, 2'b00, 5'd6);
        settle();
        check("t1_lu_freeze", {31'd0, ifc_f.Freeze}, 32'd1);
        check("t1_lu_bubble", {31'd0, ifc_f.Bubble}, 32'd1);
        tick();
        settle();
        check("t1_after_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t1_stall_cnt", ifc_f.Stall_cnt, 32'd1);

        // 2: ALU writer of r7 followed by reader -> forwarding, no stall
        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 5'd7);
        tick();
        put(5'd7, 5'd0, 1'b0, 1'b1, 2'b00, 5'd8);
        settle();
        check("t2_f_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t2_b_bubble", {31'd0, ifc_b.Bubble}, 32'd1);
        tick();
        check("t2_f_stall_cnt", ifc_f.Stall_cnt, 32'd0);

        // 3: no forwarding, Src2 dependency: 2 stalls (bypass) / 3 stalls (no bypass)
        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 5'd3);
        tick();
        put(5'd0, 5'd3, 1'b1, 1'b1, 2'b00, 5'd9);
        settle();
        check("t3_c1_b_freeze", {31'd0, ifc_b.Freeze}, 32'd1);
        tick();
        settle();
        check("t3_c2_b_freeze", {31'd0, ifc_b.Freeze}, 32'd1);
        tick();
        settle();
        check("t3_c3_b_freeze", {31'd0, ifc_b.Freeze}, 32'd0);
        check("t3_c3_n_bubble", {31'd0, ifc_n.Bubble}, 32'd1);
        check("t3_b_stall_cnt", ifc_b.Stall_cnt, 32'd2);
        tick();
        settle();
        check("t3_c4_n_freeze", {31'd0, ifc_n.Freeze}, 32'd0);
        check("t3_n_stall_cnt", {30'd0, ifc_n.Stall_cnt}, 32'd3);
        tick();
        put(5'd9, 5'd0, 1'b0, 1'b1, 2'b00, 5'd10);
        settle();
        check("t3_n_second_stall", {31'd0, ifc_n.Bubble}, 32'd1);
        tick();
        check("t3_n_cnt_wrap", {30'd0, ifc_n.Stall_cnt}, 32'd0);

        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 5'd3);
        tick();
        put(5'd0, 5'd3, 1'b0, 1'b1, 2'b00, 5'd9);
        settle();
        check("t3_src2_unused", {31'd0, ifc_b.Freeze}, 32'd0);

        // 4: r0 never causes a hazard
        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 5'd0);
        tick();
        put(5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 5'd4);
        settle();
        check("t4_r0_f", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t4_r0_b", {31'd0, ifc_b.Freeze}, 32'd0);
        check("t4_r0_n", {31'd0, ifc_n.Freeze}, 32'd0);

        // 5: branch taken while a load-use hazard is present
        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 5'd5);
        tick();
        put(5'd5, 5'd0, 1'b0, 1'b1, 2'b00, 5'd6);
        br = 1'b1;
        settle();
        check("t5_flush",  {31'd0, ifc_f.Flush},  32'd1);
        check("t5_bubble", {31'd0, ifc_f.Bubble}, 32'd0);
        check("t5_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        tick();
        br = 1'b0;
        settle();
        check("t5_exe_cleared", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t5_flush_cnt", ifc_f.Flush_cnt, 32'd1);
        check("t5_stall_cnt", ifc_f.Stall_cnt, 32'd0);

        // 6: Mem_wait during a load-use stall, then reset during a stall
        do_reset();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 5'd5);
        tick();
        put(5'd5, 5'd0, 1'b0, 1'b1, 2'b00, 5'd6);
        mw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            br = (i == 1);
            settle();
            check("t6_hold_all", {31'd0, ifc_f.Hold_all}, 32'd1);
            check("t6_wait_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
            check("t6_wait_bubble", {31'd0, ifc_f.Bubble}, 32'd0);
            check("t6_wait_flush", {31'd0, ifc_f.Flush}, 32'd0);
            tick();
            check("t6_wait_stall_cnt", ifc_f.Stall_cnt, 32'd0);
            check("t6_wait_flush_cnt", ifc_f.Flush_cnt, 32'd0);
        end
        mw = 1'b0;
        br = 1'b0;
        settle();
        check("t6_resume_bubble", {31'd0, ifc_f.Bubble}, 32'd1);
        check("t6_hold_drop", {31'd0, ifc_f.Hold_all}, 32'd0);
        tick();
        settle();
        check("t6_done_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t6_stall_cnt", ifc_f.Stall_cnt, 32'd1);
        tick();
        put(5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 5'd5);
        tick();
        put(5'd5, 5'd0, 1'b0, 1'b1, 2'b00, 5'd6);
        settle();
        check("t6_stall2_bubble", {31'd0, ifc_f.Bubble}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        check("t6_rst_freeze", {31'd0, ifc_f.Freeze}, 32'd0);
        check("t6_rst_bubble", {31'd0, ifc_f.Bubble}, 32'd0);
        check("t6_rst_stall_cnt", ifc_f.Stall_cnt, 32'd0);
        check("t6_rst_flush_cnt", ifc_f.Flush_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
